// File: rtl/stream_demux_1_4_pkg.sv
// Shared constants, index type and helpers for the 1:4 stream demux.
// Package demux_pkg: N_CH, SEL_W, CNT_W, sel_t, sel_onehot().
package demux_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 8;

    typedef logic [SEL_W-1:0] sel_t;

    // One-hot decode of a channel index.
    function automatic logic [N_CH-1:0] sel_onehot(input sel_t s);
        logic [N_CH-1:0] v;
        v = '0;
        v[s] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/stream_demux_1_4_if.sv
// Bundle of upstream and downstream stream signals for stream_demux_1_4.
// Signals: up_valid/up_ready/up_sel/up_data, dn_valid/dn_ready/dn_data,
// and dn_count when DEMUX_COUNT_EN is defined.
// Modports: slave = demux side, master = producer/consumer side.
interface stream_demux_1_4_if
    import demux_pkg::*;
#(
    parameter int W = 4
);

    logic              up_valid;
    logic              up_ready;
    sel_t              up_sel;
    logic [W-1:0]      up_data;
    logic [N_CH-1:0]   dn_valid;
    logic [N_CH-1:0]   dn_ready;
    logic [N_CH*W-1:0] dn_data;
`ifdef DEMUX_COUNT_EN
    logic [N_CH*CNT_W-1:0] dn_count;
`endif

    modport slave (
        input  up_valid,
        input  up_sel,
        input  up_data,
        input  dn_ready,
        output up_ready,
        output dn_valid,
        output dn_data
`ifdef DEMUX_COUNT_EN
        ,
        output dn_count
`endif
    );

    modport master (
        output up_valid,
        output up_sel,
        output up_data,
        output dn_ready,
        input  up_ready,
        input  dn_valid,
        input  dn_data
`ifdef DEMUX_COUNT_EN
        ,
        input  dn_count
`endif
    );

endinterface

// File: rtl/stream_demux_1_4_out_slot.sv
// One-entry valid/ready output register (module out_slot).
// Ports: clk, rst_n, i_push_valid, i_push_data, o_push_ready,
// o_valid, o_data, i_pop_ready.
module out_slot #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push_valid,
    input  logic [W-1:0] i_push_data,
    output logic         o_push_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_pop_ready
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_push;
    logic         w_pop;

    // Room exists when empty or when the held beat leaves this cycle.
    assign o_push_ready = ~r_valid | i_pop_ready;
    assign w_push       = i_push_valid & o_push_ready;
    assign w_pop        = r_valid & i_pop_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (w_push) begin
                r_valid <= 1'b1;
                r_data  <= i_push_data;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/stream_demux_1_4.sv
// Valid/ready 1:4 stream demux: each upstream beat goes to the
// output slot chosen by up_sel; a stalled slot blocks only its beats.
// Ports: clk, rst_n, bus (stream_demux_1_4_if.slave).
// Macro DEMUX_COUNT_EN adds per-channel 8-bit accepted-beat counters.
module stream_demux_1_4
    import demux_pkg::*;
#(
    parameter int W = 4
) (
    input logic                clk,
    input logic                rst_n,
    stream_demux_1_4_if.slave  bus
);

    logic [N_CH-1:0]   w_push;
    logic [N_CH-1:0]   w_slot_rdy;
    logic [N_CH-1:0]   w_dn_valid;
    logic [N_CH*W-1:0] w_dn_data;

    assign w_push = {N_CH{bus.up_valid}} & sel_onehot(bus.up_sel);

    for (genvar g = 0; g < N_CH; g++) begin : g_slot
        out_slot #(
            .W (W)
        ) u_slot (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_push_valid (w_push[g]),
            .i_push_data  (bus.up_data),
            .o_push_ready (w_slot_rdy[g]),
            .o_valid      (w_dn_valid[g]),
            .o_data       (w_dn_data[g*W +: W]),
            .i_pop_ready  (bus.dn_ready[g])
        );
    end

    // Ready depends only on the addressed slot, never on up_valid.
    assign bus.up_ready = w_slot_rdy[bus.up_sel];
    assign bus.dn_valid = w_dn_valid;
    assign bus.dn_data  = w_dn_data;

`ifdef DEMUX_COUNT_EN
    logic [N_CH-1:0]            w_acc;
    logic [N_CH-1:0][CNT_W-1:0] r_cnt;

    assign w_acc = w_push & w_slot_rdy;

    // Free-running wrap at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_acc[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign bus.dn_count = r_cnt;
`endif

endmodule

// File: doc/stream_demux_1_4.md
Name: stream_demux_1_4

Overview:
- Valid/ready stream demultiplexer: one upstream channel carries data plus a 2-bit index, routed to one of 4 downstream channels.
- Counterpart to the indexed 4:1 mux. It sits where one producer feeds four consumers selected per beat.
- Each downstream channel has its own one-entry output register. A stalled consumer blocks only beats addressed to it.

Parameters:
- W, 4, data width in bits.
- N, 4, number of output channels; fixed at 4 in this revision (index width 2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- up_valid  in  1  upstream beat valid.
- up_ready  out  1  upstream beat accepted when up_valid and up_ready are both high.
- up_sel  in  2  destination index 0..3, qualified by up_valid.
- up_data  in  W  upstream payload.
- dn_valid  out  4  per-channel output valid, bit i = channel i.
- dn_ready  in  4  per-channel consumer ready.
- dn_data  out  4*W  packed outputs, channel i at bits [i*W +: W].
- dn_count  out  4*8  per-channel accepted-beat counters (only with DEMUX_COUNT_EN).

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous and active-low.
- Reset values: dn_valid = 0; dn_data = 0; dn_count = 0 (if present). up_ready follows from these combinationally.
- Output register i holds a beat (dn_valid[i]=1) until dn_ready[i]=1, then releases it.
- dn_valid[i] never drops without a handshake. dn_data[i] is stable while dn_valid[i]=1 and dn_ready[i]=0.
- up_ready = ~dn_valid[up_sel] | dn_ready[up_sel].
  - Combinational from up_sel, dn_valid and dn_ready.
  - Independent of up_valid, so up_ready may be high with up_valid low.
- Accept with up_valid and up_ready high: at the next edge, reg[up_sel] loads up_data and dn_valid[up_sel] becomes 1.
- Latency: 1 cycle from acceptance to dn_valid.
- Throughput: 1 beat/cycle, including back-to-back beats to the same channel with dn_ready held high.
- Simultaneous pop and push on the same channel: register reloads, dn_valid stays 1, no bubble.
- Pop on channel i with no push to i: dn_valid[i] clears at the edge.
- Push to channel i while a pop completes on channel j≠i: both take effect in the same edge.
- Channels not addressed and not popped hold their state.
- Blocking:
  - If the addressed channel is full and its dn_ready=0, up_ready=0 and the upstream beat waits.
  - up_sel, up_data and up_valid must stay stable while waiting; this is an upstream protocol obligation, checked in the bench.
  - No reordering within a channel. No ordering guarantee across channels beyond acceptance order.
- Reset mid-operation: all held beats are dropped, dn_valid=0 asynchronously, counters cleared.
- Data bits of an empty register are don't-care for consumers. The RTL may leave them unchanged.

Optional Feature:
- DEMUX_COUNT_EN defined:
  - The dn_count port exists.
  - Counter i increments by 1 on each accepted upstream beat with up_sel==i.
  - 8-bit, wraps 255→0, no saturation. Reset to 0.
- DEMUX_COUNT_EN undefined: the dn_count port and counters are absent. Datapath behaviour is identical.

Decomposition:
- Shared package demux_pkg:
  - localparam N_CH=4 and SEL_W=2.
  - typedef sel_t (logic [SEL_W-1:0]).
  - localparam CNT_W=8.
- Sub-module out_slot: one-entry valid/ready register with push (valid, data) and pop (ready) ports and an async active-low reset.
- The top instantiates 4 out_slots in a generate loop, plus the index decode and the up_ready mux.

Test Plan:
- Reset then idle, all dn_ready=1: dn_valid=0000, up_ready=1. Assert rst_n=0 mid-run with channel 2 full → dn_valid=0000 immediately.
- Push sel=0..3 with data 0xA,0xB,0xC,0xD over 4 cycles, dn_ready=1111 → dn_valid pulses 0001,0010,0100,1000 one cycle later, with dn_data slice matching.
- Stall channel 1: dn_ready=1101, push sel=1 data 5 then sel=1 data 6.
  - Expected: first accepted; second sees up_ready=0 and is held; channel 1 keeps data 5.
  - Raising dn_ready[1] → data 5 pops and data 6 loads the same edge.
- Head-of-line isolation: channel 1 stalled full, push sel=3 data 9 → accepted, dn_valid[3]=1 next cycle.
- Same-channel streaming: 16 beats to sel=2, data 0..15, dn_ready[2]=1 → 16 consecutive cycles of dn_valid[2]=1, in-order data, no bubbles.
- With DEMUX_COUNT_EN: 257 beats to sel=0 and 3 to sel=3 → dn_count ch0=1 (wrapped), ch3=3, ch1=ch2=0.
